// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
// Provides seg_pat_t, SEG_OFF and the 16-entry hex glyph table (active-high {g..a}).
package seg_pkg;

  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t SEG_OFF = 7'h00;

  // Glyphs for 0-9, A, b, C, d, E, F; bit 0 = segment a.
  localparam seg_pat_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_pat_t seg_lookup(
    input logic [3:0] nib
  );
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment glyph.
// Ports: nib (4-bit hex digit in), pat (active-high {g..a} out).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_pat_t   pat
);

  assign pat = seg_lookup(nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed hex display scanner with double buffer, PWM, dead time.
// Ports: clk, rst (sync high), value_i/dp_i/load_i (shadow load), bright_i (0..15),
//   seg_o {dp,g..a}, an_o (one-hot), frame_o (frame-end pulse), pending_o (shadow unshown).
//   Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYC      = 2,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  input  logic [3:0]            bright_i,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o,
  output logic                  pending_o
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  // XOR masks that map internal active-high levels onto pin polarity.
  localparam logic [7:0] SEG_INV =
    ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_INV =
    ACTIVE_LOW_AN ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow_val;
  logic [DIGITS-1:0]     shadow_dp;
  logic [4*DIGITS-1:0]   active_val;
  logic [DIGITS-1:0]     active_dp;
  logic                  pending;

  logic                  slot_end;
  logic                  frame_end;
  logic [31:0]           cnt_w;
  logic [31:0]           thresh;
  logic                  lit;
  logic [3:0]            nibs [DIGITS];
  logic [3:0]            cur_nib;
  seg_pat_t              dec_pat;
  seg_pat_t              shown_pat;
  logic                  blank;
  logic [DIGITS-1:0]     an_sel;
  logic [7:0]            seg_next;
  logic [DIGITS-1:0]     an_next;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_MAX);

  // bright 15 yields thresh == SCAN_DIV, i.e. lit to the slot end.
  assign cnt_w  = 32'(cnt);
  assign thresh = ((32'(bright_i) + 32'd1) * SCAN_DIV) >> 4;
  assign lit    = (cnt_w >= BLANK_CYC) && (cnt_w < thresh);

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      nibs[k] = active_val[4*k +: 4];
    end
  end

  assign cur_nib = nibs[idx];

  seg_hex_decode u_dec (
    .nib (cur_nib),
    .pat (dec_pat)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[k]: nibble k and every nibble above it are zero.
  logic [DIGITS-1:0] upper_zero;

  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc           = acc && (nibs[k] == 4'h0);
      upper_zero[k] = acc;
    end
  end

  assign blank = (idx != '0) && upper_zero[idx];
`else
  assign blank = 1'b0;
`endif

  assign shown_pat = blank ? SEG_OFF : dec_pat;

  always_comb begin
    an_sel      = '0;
    an_sel[idx] = 1'b1;
  end

  // Dead time and PWM off-time both force everything dark.
  assign seg_next = lit ? {active_dp[idx], shown_pat}
                        : {1'b0, SEG_OFF};
  assign an_next  = lit ? an_sel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      seg_o      <= SEG_INV;
      an_o       <= AN_INV;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end

      // A load landing on the frame-end cycle bypasses the shadow
      // so it is visible from the very next frame.
      if (load_i && frame_end) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
        active_val <= value_i;
        active_dp  <= dp_i;
        pending    <= 1'b0;
      end else if (frame_end) begin
        if (pending) begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load_i) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
        pending    <= 1'b1;
      end

      seg_o <= seg_next ^ SEG_INV;
      an_o  <= an_next ^ AN_INV;
    end
  end

  assign frame_o   = frame_end;
  assign pending_o = pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, 20-cycle slots).
// Expected lit runs are queued at stimulus time and matched as the pins show them.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 20;
  localparam int BLANK_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic [3:0]  bright_i;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;
  logic        pending_o;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_i   (value_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .bright_i  (bright_i),
    .seg_o     (seg_o),
    .an_o      (an_o),
    .frame_o   (frame_o),
    .pending_o (pending_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         dig;
    logic [7:0] seg;
    int         len;
    int         start;
  } run_t;

  run_t exp_q[$];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(
    input logic [15:0] v,
    input logic [3:0]  dp,
    input int          k
  );
    logic [6:0] p;
    p = hex7(v[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (v >> (4*k)) == 16'h0) p = 7'h00;
`endif
    return ~{dp[k], p};
  endfunction

  // One run per digit; pin-side start is two cycles after the state cycle.
  task automatic push_frame(
    input logic [15:0] v,
    input logic [3:0]  dp,
    input int          b
  );
    int   t;
    int   len;
    run_t r;
    t   = ((b + 1) * SCAN_DIV) >> 4;
    len = (t > BLANK_CYC) ? t - BLANK_CYC : 0;
    if (len > 0) begin
      for (int k = 0; k < DIGITS; k++) begin
        r.dig   = k;
        r.seg   = exp_seg(v, dp, k);
        r.len   = len;
        r.start = k * SCAN_DIV + BLANK_CYC + 2;
        exp_q.push_back(r);
      end
    end
  endtask

  bit         mon_en = 1'b0;
  int         pos    = 0;
  bit         in_run = 1'b0;
  bit         run_ok = 1'b0;
  int         r_dig;
  int         r_len;
  int         r_start;
  logic [7:0] r_seg;
  logic [3:0] r_an;

  always @(negedge clk) begin
    logic [3:0] act;
    run_t       e;
    if (rst) pos = 0;
    else if (frame_o) pos = 0;
    else pos++;
    act = ~an_o;
    if (act != 4'h0) begin
      if (!in_run) begin
        in_run  = 1'b1;
        run_ok  = mon_en;
        r_an    = act;
        r_seg   = seg_o;
        r_start = pos;
        r_len   = 0;
        r_dig   = -1;
        for (int k = 0; k < DIGITS; k++) begin
          if (act[k]) r_dig = k;
        end
        if (run_ok) chk("an_onehot", $countones(act), 1);
      end else if (run_ok) begin
        chk("run_stable", {act, seg_o}, {r_an, r_seg});
      end
      r_len++;
    end else if (in_run) begin
      in_run = 1'b0;
      if (run_ok) begin
        chk("run_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("digit", r_dig, e.dig);
          chk("seg", r_seg, e.seg);
          chk("lit_len", r_len, e.len);
          chk("lit_start", r_start, e.start);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(
    output int n,
    output int pend,
    output int act
  );
    n    = 0;
    pend = 0;
    act  = 0;
    do begin
      tick();
      n++;
      if (pending_o) pend++;
      if (an_o != 4'hF) act++;
    end while (!frame_o && n < 400);
    chk("frame_seen", frame_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pend;
    int act;
    value_i  = '0;
    dp_i     = '0;
    load_i   = 1'b0;
    bright_i = 4'd15;
    rst      = 1'b1;
    repeat (3) tick();
    chk("rst_an", an_o, 4'hF);
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_frame", frame_o, 0);
    chk("rst_pend", pending_o, 0);
    rst = 1'b0;

    repeat (5) tick();
    value_i = 16'h12AF;
    dp_i    = 4'b0101;
    load_i  = 1'b1;
    tick();
    load_i = 1'b0;
    chk("pend_load", pending_o, 1);
    wait_pulse(n, pend, act);
    chk("pend_frame_end", pending_o, 1);
    tick();
    chk("pend_clear", pending_o, 0);
    push_frame(16'h12AF, 4'b0101, 15);
    mon_en = 1'b1;
    wait_pulse(n, pend, act);
    chk("frame_period", n + 1, 80);

    tick();
    push_frame(16'h12AF, 4'b0101, 15);
    repeat (29) tick();
    value_i = 16'hDEAD;
    dp_i    = 4'b0011;
    load_i  = 1'b1;
    tick();
    load_i = 1'b0;
    chk("pend_mid", pending_o, 1);
    repeat (4) tick();
    value_i = 16'h1234;
    dp_i    = 4'b0000;
    load_i  = 1'b1;
    tick();
    load_i = 1'b0;
    wait_pulse(n, pend, act);
    chk("pend_mid_end", pending_o, 1);
    tick();
    chk("pend_mid_clr", pending_o, 0);
    push_frame(16'h1234, 4'b0000, 15);

    wait_pulse(n, pend, act);
    value_i = 16'h00FF;
    dp_i    = 4'b1000;
    load_i  = 1'b1;
    tick();
    load_i = 1'b0;
    chk("pend_bypass", pending_o, 0);
    push_frame(16'h00FF, 4'b1000, 15);
    wait_pulse(n, pend, act);
    chk("pend_never", pend, 0);

    value_i = 16'h0050;
    dp_i    = 4'b0000;
    load_i  = 1'b1;
    tick();
    load_i = 1'b0;
    push_frame(16'h0050, 4'b0000, 15);
    wait_pulse(n, pend, act);

    repeat (3) tick();
    bright_i = 4'd3;
    push_frame(16'h0050, 4'b0000, 3);
    wait_pulse(n, pend, act);
    repeat (3) tick();
    chk("q_drain_b3", exp_q.size(), 0);
    bright_i = 4'd0;
    wait_pulse(n, pend, act);
    chk("dark_frame", act, 0);
    repeat (3) tick();
    bright_i = 4'd15;
    chk("q_drain_b0", exp_q.size(), 0);
    mon_en = 1'b0;

    wait_pulse(n, pend, act);
    repeat (45) tick();
    value_i = 16'hBEEF;
    dp_i    = 4'b1111;
    load_i  = 1'b1;
    tick();
    load_i = 1'b0;
    chk("pend_pre_rst", pending_o, 1);
    repeat (6) tick();
    chk("pre_rst_an", an_o, 4'hB);
    rst = 1'b1;
    tick();
    chk("mid_rst_an", an_o, 4'hF);
    chk("mid_rst_seg", seg_o, 8'hFF);
    chk("mid_rst_frame", frame_o, 0);
    chk("mid_rst_pend", pending_o, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    push_frame(16'h0000, 4'b0000, 15);
    wait_pulse(n, pend, act);
    chk("rst_restart", n, 79);
    repeat (3) tick();
    chk("q_drain_end", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller; next generation of the fixed 8-digit hex display path hanging off the CPU debug/output register in the min SoC top. Displays DIGITS hex nibbles by time-multiplexing shared segment lines across DIGITS anodes. Adds a tear-free double-buffered update, 16-step brightness PWM, inter-digit dead time and configurable output polarity.

Parameters:
DIGITS, 8, number of digits / anode lines (1..16)
SCAN_DIV, 1000, clk cycles per digit slot (>= BLANK_CYC+16)
BLANK_CYC, 2, dead-time cycles at start of each slot with all anodes off
ACTIVE_LOW_SEG, 1, 1 = seg_o bits driven low to light
ACTIVE_LOW_AN, 1, 1 = an_o bit driven low to select digit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
value_i  in  4*DIGITS  hex nibbles; nibble k ([4k+3:4k]) shown on digit k
dp_i  in  DIGITS  decimal point per digit
load_i  in  1  one-cycle strobe: capture value_i/dp_i into shadow buffer
bright_i  in  4  brightness 0 (dimmest) .. 15 (full)
seg_o  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW_SEG
an_o  out  DIGITS  one-hot digit select, polarity per ACTIVE_LOW_AN
frame_o  out  1  one-cycle pulse at end of each full scan
pending_o  out  1  shadow holds data not yet shown

Behaviour:
- Reset: prescaler=0, digit index=0, shadow/active buffers=0, pending_o=0, frame_o=0, an_o all inactive, seg_o all off (polarity-adjusted).
- Prescaler counts 0..SCAN_DIV-1, wraps to 0. On wrap, digit index increments; DIGITS-1 wraps to 0 = frame end.
- Frame end cycle: frame_o=1 for exactly that cycle; if pending, active<=shadow, pending cleared.
- load_i: shadow<=value_i/dp_i, pending<=1. Repeated loads before frame end: last wins.
- load_i coincident with frame end: value_i/dp_i go straight to active, pending stays 0.
- Brightness threshold T = ((bright_i+1)*SCAN_DIV)>>4; bright_i sampled each cycle. bright_i=15 gives T=SCAN_DIV.
- Digit k lit in cycle when index==k and BLANK_CYC <= prescaler < T; otherwise all anodes inactive, segments off. If T <= BLANK_CYC, digit never lit (dark, not error).
- seg_o/an_o registered: one cycle latency from prescaler/index state.
- Decode (active-high internal, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bit7=dp.
- Polarity inversion applied after decode and gating; affects only output pins.
- Reset mid-frame: immediately returns to reset state, shadow content discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN: defined -> a digit k>0 whose nibble and all higher nibbles are 0 in active buffer is blanked (segments off, dp still shown, anode still driven per timing); digit 0 always shown. Undefined -> all digits always decoded.

Decomposition:
- seg_pkg: 16-entry seg pattern constant array, seg_pat_t (7-bit) typedef, SEG_OFF constant.
- Sub-module seg_hex_decode: combinational nibble -> 7-bit pattern, one instance on the muxed nibble.

Test Plan:
- DIGITS=4, SCAN_DIV=20, BLANK_CYC=2, bright=15; load 16'h12AF -> digit0 seg 71, digit1 77, digit2 5B, digit3 06 (inverted on pins); each anode active cycles 2..19 of its slot; frame_o every 80 cycles.
- load 16'h1234 mid-frame -> old value shown until frame_o, 1234 from next slot 0; pending_o 1 then 0.
- load_i on frame-end cycle with 16'h00FF -> shown in the very next frame, pending_o never asserts.
- bright_i=3 (T=5) -> anode active prescaler 2..4 only; bright_i=0 (T=1) -> all anodes inactive entire frame.
- Assert rst mid-slot with digit2 lit -> next cycle an_o all inactive, seg_o off, frame_o 0, scan restarts at digit0.
- With LEADING_ZERO_BLANK_EN, value 16'h0050 -> digit3, digit2 segments off, digit1 6D, digit0 3F; 16'h0000 -> only digit0 shows 3F.
